// File: rtl/mem_bus_arbiter_if.sv
// Shared bus bundle between the two masters, the arbiter and the memory/peripheral slaves.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_rd;
  logic              m0_wr;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic              m1_rd;
  logic              m1_wr;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic [ADDR_W-1:0] oMemAddr;
  logic              oMemRead;
  logic              oMemWrite;
  logic [DATA_W-1:0] oMemWriteData;
  logic [DATA_W-1:0] iMemReadData;
  logic [1:0]        owner;

  modport slave (
    input  m0_req, m0_rd, m0_wr, m0_lock, m0_addr, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_rd, m1_wr, m1_lock, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output oMemAddr, oMemRead, oMemWrite, oMemWriteData, owner,
    input  iMemReadData
  );

  modport master (
    output m0_req, m0_rd, m0_wr, m0_lock, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_rd, m1_wr, m1_lock, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack,
    input  oMemAddr, oMemRead, oMemWrite, oMemWriteData, owner,
    output iMemReadData
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded lock bursts.
// Each transaction takes IDLE -> ACCESS (bus strobe) -> RESP (ack pulse).
module mem_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_bus_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  state_t            state_q, state_d;
  logic              cmd_rd_q, cmd_rd_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              winner_q, winner_d;
  logic              lock_q, lock_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic grant1;
  logic other_req;

  // winner_q doubles as the last winner once the transaction has finished
  always_comb begin
    state_d     = state_q;
    cmd_rd_d    = cmd_rd_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    winner_d    = winner_q;
    lock_d      = lock_q;
    burst_cnt_d = burst_cnt_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    grant1      = 1'b0;
    other_req   = 1'b0;

    if (bus.m0_req && bus.m1_req) begin
      if ((burst_cnt_q < MAX_BURST_C) && lock_q) grant1 = winner_q;
      else                                       grant1 = ~winner_q;
    end else begin
      grant1 = ~bus.m0_req;
    end
    other_req = grant1 ? bus.m0_req : bus.m1_req;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d     = ACCESS;
          winner_d    = grant1;
          cmd_rd_d    = grant1 ? bus.m1_rd    : bus.m0_rd;
          cmd_wr_d    = grant1 ? bus.m1_wr    : bus.m0_wr;
          cmd_addr_d  = grant1 ? bus.m1_addr  : bus.m0_addr;
          cmd_wdata_d = grant1 ? bus.m1_wdata : bus.m0_wdata;
          lock_d      = grant1 ? bus.m1_lock  : bus.m0_lock;
          if ((grant1 == winner_q) && other_req) burst_cnt_d = burst_cnt_q + 4'd1;
          else                                   burst_cnt_d = 4'd1;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (cmd_rd_q && !cmd_wr_q) begin
          if (winner_q) m1_rdata_d = bus.iMemReadData;
          else          m0_rdata_d = bus.iMemReadData;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Last winner resets to master 1 so master 0 takes the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cmd_rd_q    <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      winner_q    <= 1'b1;
      lock_q      <= 1'b0;
      burst_cnt_q <= 4'd0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      winner_q    <= winner_d;
      lock_q      <= lock_d;
      burst_cnt_q <= burst_cnt_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign bus.oMemAddr      = cmd_addr_q;
  assign bus.oMemWriteData = cmd_wdata_q;
  assign bus.oMemRead      = (state_q == ACCESS) && cmd_rd_q && !cmd_wr_q;
  assign bus.oMemWrite     = (state_q == ACCESS) && cmd_wr_q;
  assign bus.m0_ack        = (state_q == RESP) && !winner_q;
  assign bus.m1_ack        = (state_q == RESP) && winner_q;
  assign bus.m0_rdata      = m0_rdata_q;
  assign bus.m1_rdata      = m1_rdata_q;
  assign bus.owner         = (state_q == IDLE) ? 2'b00 : (winner_q ? 2'b10 : 2'b01);

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single peripheral/data-memory bus (address, read, write, write data, read data) between the CPU core's data port (master 0) and a second bus master such as a UART loader/DMA engine (master 1). Each master uses a req/ack handshake. The arbiter picks a winner round-robin, optionally honouring a bounded lock, and drives one bus access per transaction. It returns registered read data with a one-cycle ack pulse. It sits between the masters and the Peripheral/data-memory slaves, on the divided CPU clock.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BURST, 4, max consecutive locked grants to one master while the other is requesting (1..15)

- clk  in  1  bus clock (divided CPU clock)
- reset  in  1  asynchronous, active-low reset
- mN_req  in  1  master N (N=0,1) request; held high with command stable until ack
- mN_rd / mN_wr  in  1  read / write command
- mN_lock  in  1  request priority for this master's next transaction
- mN_addr  in  ADDR_W  address
- mN_wdata  in  DATA_W  write data
- mN_rdata  out  DATA_W  captured read data, valid when mN_ack=1, held afterwards
- mN_ack  out  1  one-cycle completion pulse
- oMemAddr  out  ADDR_W  bus address
- oMemRead / oMemWrite  out  1  bus strobes
- oMemWriteData  out  DATA_W  bus write data
- iMemReadData  in  DATA_W  bus read data, combinational from slaves
- owner  out  2  00 idle, 01 master 0, 10 master 1 (status/debug)

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Any req: choose winner, latch its rd/wr/addr/wdata into command registers, record winner, go to ACCESS.
- Winner selection:
  - Single requester wins.
  - Both requesting and burst_cnt < MAX_BURST and the last winner asserted lock on its previous transaction: last winner wins again.
  - Otherwise the master not granted last wins (round-robin).
- burst_cnt:
  - Increments when the same master is granted consecutively while the other has req=1.
  - Resets to 1 on a change of winner, and when the other master is not requesting.
- ACCESS, exactly 1 cycle:
  - Bus outputs driven from the latched command.
  - oMemRead = rd & ~wr. Write wins if both are set.
  - oMemWrite = wr.
  - A req with neither rd nor wr still completes, with no bus strobe.
  - At the cycle's end, iMemReadData is captured into winner's mN_rdata, only if the access was a read.
  - Next state: RESP.
- RESP, 1 cycle:
  - Winner's mN_ack = 1; strobes low.
  - Next state: IDLE.
- The master may change req/command at the edge ending its ack cycle. The arbiter samples req again only in IDLE, so a single req is never served twice.
- Loser's req stays pending, unacknowledged, and is served on the next IDLE.
- Outside ACCESS:
  - oMemRead = oMemWrite = 0.
  - oMemAddr/oMemWriteData hold their last values.
- owner is nonzero in ACCESS and RESP.

## Timing
- Reset values:
  - state IDLE; all outputs 0; command registers 0.
  - last-winner = master 1, so master 0 wins the first tie.
  - burst_cnt = 0.
- Transaction latency: req high in IDLE at edge k → strobe during cycle k+1 → ack during cycle k+2. Three cycles per transaction.
- Back-to-back: both masters continuously requesting without lock alternate 0,1,0,1. Each sees one transaction every 6 cycles.
- Reset asserted mid-ACCESS or mid-RESP:
  - Strobes and ack drop immediately; no ack is issued.
  - A write strobe cut mid-cycle is not guaranteed complete.
  - The master re-issues after reset.
- Req withdrawn before ack: protocol violation. Arbiter behaviour is undefined except that it returns to IDLE within 2 cycles.

## Test plan
- Single read: m0 req, rd=1, addr 0x40000010; slave returns 0x000000A5 → oMemRead high 1 cycle with addr 0x40000010; m0_ack on the following cycle with m0_rdata=0x000000A5; m1_ack never pulses.
- Tie after reset: m0 and m1 both request writes (0x1111, 0x2222) in the same cycle → m0 served first, then m1; bus sees wdata 0x1111 then 0x2222, 3 cycles apart.
- Lock burst: MAX_BURST=4, m1 lock=1 issuing reads continuously, m0 requesting → m1 granted 4 times consecutively, then m0 granted once, then m1 again.
- rd and wr both high from m0 with wdata 0xDEADBEEF → oMemWrite=1, oMemRead=0; m0_rdata unchanged from its prior value; m0_ack pulses once.
- Reset pulled low during ACCESS of an m1 write → oMemWrite, m1_ack and owner go 0 asynchronously; after release, first tie goes to m0.
